// File: rtl/priority_encoder_4to2.sv
// Registered 4-to-2 encoder: captures request pulses into a pending
// register and emits one granted index per valid/ready handshake.
//
// Ports:
//   clk     - rising-edge clock
//   rst     - asynchronous active-high reset
//   en      - request capture enable (req ignored when low)
//   req     - four request lines, any number may be high
//   ready   - downstream accepts code when valid && ready
//   code    - registered 2-bit index of the granted line
//   valid   - code holds an unconsumed result
//   pending - current pending-request register
//   collide - one-cycle pulse when a request merged into a pending bit
//
// Build option: define PRIORITY_ENCODER_RR_EN for round-robin winner
// selection; otherwise the highest pending index always wins.

module priority_encoder_4to2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] req,
  input  logic       ready,
  output logic [1:0] code,
  output logic       valid,
  output logic [3:0] pending,
  output logic       collide
);

  logic [3:0] pending_q, pending_d;
  logic [1:0] code_q, code_d;
  logic       valid_q, valid_d;
  logic       collide_q, collide_d;

  logic [3:0] set;
  logic [3:0] clr;
  logic       load;
  logic       grant;
  logic [1:0] win;

  assign set   = en ? req : 4'b0000;
  assign load  = !valid_q || ready;
  assign grant = load && (pending_q != 4'b0000);

`ifdef PRIORITY_ENCODER_RR_EN

  logic [1:0] ptr_q, ptr_d;
  logic [1:0] idx;
  logic       found;

  // Search ascends from the slot after the last winner, wrapping,
  // so each line gets a turn before any line is served twice.
  always_comb begin
    win   = 2'd0;
    found = 1'b0;
    idx   = 2'd0;
    for (int unsigned k = 1; k < 5; k++) begin
      idx = ptr_q + k[1:0];
      if (!found && pending_q[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (grant) ptr_d = win;
  end

  // Reset value 3 makes bit 0 the first candidate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= 2'd3;
    else     ptr_q <= ptr_d;
  end

`else

  // Fixed priority: highest index wins.
  always_comb begin
    win = 2'd0;
    priority case (1'b1)
      pending_q[3]: win = 2'd3;
      pending_q[2]: win = 2'd2;
      pending_q[1]: win = 2'd1;
      default:      win = 2'd0;
    endcase
  end

`endif

  assign clr = grant ? (4'b0001 << win) : 4'b0000;

  // Set wins over clear, so a bit requested while being granted
  // re-arms instead of being reported as lost.
  always_comb begin
    pending_d = (pending_q & ~clr) | set;
    collide_d = |(set & pending_q & ~clr);
    code_d    = code_q;
    valid_d   = valid_q;
    if (load) begin
      valid_d = grant;
      if (grant) code_d = win;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= 4'b0000;
      code_q    <= 2'b00;
      valid_q   <= 1'b0;
      collide_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
      collide_q <= collide_d;
    end
  end

  assign code    = code_q;
  assign valid   = valid_q;
  assign pending = pending_q;
  assign collide = collide_q;

endmodule
